alu_issue: RTL and testbench
============================

# alu_issue

Command issue stage directly upstream of the 4-bit ALU. It accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. It presents one command at a time to the ALU from a registered output stage with its own valid/ready handshake. Optionally, it forwards the previous ALU result into operand A for chained operations.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of the FIFO and the output stage.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  stage can accept a command; equals !full.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_op  in  3  ALU opcode (alu_pkg encoding).
- cmd_fwd  in  1  replace A with the previous ALU result (see Configuration).
- alu_valid  out  1  output stage holds a command.
- alu_ready  in  1  ALU side consumes the command this cycle.
- alu_a  out  4  registered operand A to the ALU.
- alu_b  out  4  registered operand B to the ALU.
- alu_op  out  3  registered opcode to the ALU.
- res_s  in  4  ALU result S for the command currently on alu_*.
- level  out  $clog2(DEPTH)+1  number of FIFO entries, excluding the output stage.

## Operation
- Push: cmd_valid && cmd_ready. Pop from the output stage: alu_valid && alu_ready.
- FIFO storage, circular:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally.
  - count is 0..DEPTH; full = (count == DEPTH).
- Output-stage load happens when the stage is empty or being popped this cycle. Source:
  - FIFO head, if the FIFO is non-empty.
  - Otherwise the incoming push (bypass); the FIFO is then not written.
  - Otherwise the stage goes empty (alu_valid falls).
- Ordering is strictly FIFO; there is no reordering.
- Full: cmd_ready = 0 even if a pop occurs the same cycle. There is no pass-through when full.
- Simultaneous push and FIFO read while non-empty: count is unchanged and both pointers advance.
- Outputs alu_a/alu_b/alu_op hold stable while alu_valid && !alu_ready.
- Opcode is passed through unchanged; no decoding or validity check is done.
- flush:
  - Next cycle: count = 0, pointers = 0, alu_valid = 0, last_s = 0.
  - Flush wins over a same-cycle push; the pushed command is dropped. cmd_ready still reflects !full that cycle.
  - A same-cycle pop is still considered consumed by the ALU.

## Timing
- Reset values: cmd_ready = 1, alu_valid = 0, alu_a = 0, alu_b = 0, alu_op = 0, level = 0. Internal last_s = 0.
- Latency, push to alu_valid:
  - 1 cycle when the FIFO is empty and the output stage is empty or popping.
  - Otherwise the command is queued behind older entries.
- Throughput: 1 command/cycle sustained with alu_ready held high.
- Reset mid-operation: all queued and in-flight commands are lost; outputs return to reset values asynchronously.
- level updates one cycle after the push/pop that changes it.

## Configuration
- Macro: ALU_ISSUE_FWD_EN.
- With the macro defined:
  - last_s captures res_s on every pop.
  - When a command with cmd_fwd = 1 is loaded into the output stage, alu_a takes res_s if a pop occurs in the same cycle, else last_s.
  - cmd_a is ignored for such a command.
  - Forwarding is resolved at output-stage load, not at push.
- With the macro undefined: cmd_fwd is ignored; alu_a always equals cmd_a; last_s is not implemented.
- The port list is identical in both builds.

## Structure
- Package alu_pkg:
  - Opcode localparams shared with the ALU: ADD = 3'b000, SUB = 3'b001, NOT = 3'b010, AND = 3'b011, OR = 3'b100, XOR = 3'b101, SLT = 3'b110, EQU = 3'b111.
  - typedef alu_cmd_t: packed struct {fwd, op[2:0], a[3:0], b[3:0]}.
- One sub-module: alu_cmd_fifo. It holds the parameterised DEPTH storage, pointers, count, full/empty, and synchronous clear. alu_issue instantiates it and owns the output stage, bypass and forwarding.

## Test plan
- Reset then a single push of {a=3, b=5, op=ADD} with alu_ready = 1 → alu_valid = 1 next cycle with alu_a=3, alu_b=5, alu_op=000. alu_valid = 0 the cycle after.
- alu_ready held 0 while pushing 5 commands, DEPTH = 4 → first command in the output stage, level = 4, cmd_ready = 0. The 6th push is stalled. Raising alu_ready drains all 5 in order, one per cycle.
- Full FIFO with a pop in the same cycle as cmd_valid → push not accepted that cycle; cmd_ready = 1 the next cycle; level = 3.
- FWD_EN build: push {a=2, b=3, ADD}, then {a=9, b=1, SUB, fwd=1}, with res_s driven by a model ALU → second issue has alu_a = 5. Non-FWD build: alu_a = 9.
- flush asserted with 3 queued entries and a concurrent push → next cycle level = 0, alu_valid = 0; the pushed command never appears.
- rst asserted mid-stream, asynchronous to clk → alu_valid drops immediately, level = 0, cmd_ready = 1. Traffic after reset issues correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and command record for the ALU issue path.
package alu_pkg;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] NOT = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] OR  = 3'b100;
  localparam logic [2:0] XOR = 3'b101;
  localparam logic [2:0] SLT = 3'b110;
  localparam logic [2:0] EQU = 3'b111;

  typedef struct packed {
    logic       fwd;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command buffer: DEPTH entries, naturally wrapping pointers, occupancy count.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  alu_cmd_t                 din,
  output alu_cmd_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  alu_cmd_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      // simultaneous write and read leaves occupancy unchanged
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of the 4-bit ALU: command FIFO, bypass, registered output stage.
// Define ALU_ISSUE_FWD_EN to forward the previous ALU result into operand A.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_a,
  input  logic [3:0]             cmd_b,
  input  logic [2:0]             cmd_op,
  input  logic                   cmd_fwd,
  output logic                   alu_valid,
  input  logic                   alu_ready,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_op,
  input  logic [3:0]             res_s,
  output logic [$clog2(DEPTH):0] level
);

  alu_cmd_t cmd_in, head, nxt;
  logic     full, empty, push, pop, load, fifo_wr, fifo_rd, nxt_valid;
  logic [3:0] nxt_a;

  assign cmd_in    = '{fwd: cmd_fwd, op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = alu_valid && alu_ready;
  assign load      = !alu_valid || pop;

  // stage refills from the FIFO head first; an empty FIFO lets the push bypass
  assign fifo_rd   = load && !empty && !flush;
  assign fifo_wr   = push && !(load && empty) && !flush;
  assign nxt       = empty ? cmd_in : head;
  assign nxt_valid = !empty || push;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .wr_en (fifo_wr),
    .rd_en (fifo_rd),
    .din   (cmd_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (level)
  );

`ifdef ALU_ISSUE_FWD_EN
  logic [3:0] last_s;

  // a result leaving the ALU this very cycle is newer than last_s
  assign nxt_a = nxt.fwd ? (pop ? res_s : last_s) : nxt.a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_s <= '0;
    else if (flush) last_s <= '0;
    else if (pop)   last_s <= res_s;
  end
`else
  logic unused_fwd;

  assign nxt_a      = nxt.a;
  assign unused_fwd = ^{res_s, nxt.fwd};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
    end else if (flush) begin
      alu_valid <= 1'b0;
    end else if (load) begin
      alu_valid <= nxt_valid;
      if (nxt_valid) begin
        alu_a  <= nxt_a;
        alu_b  <= nxt.b;
        alu_op <= nxt.op;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: accepted pushes queue expectations, a monitor checks issues.
module tb_alu_issue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic       cmd_valid = 1'b0, cmd_fwd = 1'b0, alu_ready = 1'b0;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic       cmd_ready, alu_valid;
  logic [3:0] alu_a, alu_b, res_s;
  logic [2:0] alu_op;
  logic [$clog2(DEPTH):0] level;

  int checks = 0, errors = 0, pops = 0, pops0 = 0;
  logic [10:0] exp_q[$];
  logic [3:0]  fwd_a = '0;

  // {op, a, b} stimulus table
  logic [10:0] vec [5] = '{ {ADD, 4'h1, 4'h2}, {SUB, 4'h7, 4'h3}, {NOT, 4'hA, 4'h0},
                            {AND, 4'hC, 4'hA}, {XOR, 4'h5, 4'hE} };

  always #5 clk = ~clk;

  alu_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_fwd(cmd_fwd),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .res_s(res_s), .level(level)
  );

  function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    case (op)
      SUB:     return a - b;
      NOT:     return ~a;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      SLT:     return 4'(a < b);
      EQU:     return 4'(a == b);
      default: return a + b;
    endcase
  endfunction

  assign res_s = alu_model(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [10:0] v, input logic f);
    cmd_valid = 1'b1;
    {cmd_op, cmd_a, cmd_b} = v;
    cmd_fwd = f;
  endtask

  // monitor: compare issues against the queue, then record accepted pushes
  always @(negedge clk) begin
    logic [10:0] e;
    logic [3:0]  exp_a;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (alu_valid && alu_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty actual=%0h required=none", {alu_op, alu_a, alu_b});
        end else begin
          e = exp_q.pop_front();
          chk("sb_issue", {21'd0, alu_op, alu_a, alu_b}, {21'd0, e});
        end
      end
`ifdef ALU_ISSUE_FWD_EN
      exp_a = cmd_fwd ? fwd_a : cmd_a;
`else
      exp_a = cmd_a;
`endif
      if (flush) exp_q.delete();
      else if (cmd_valid && cmd_ready) exp_q.push_back({cmd_op, exp_a, cmd_b});
    end
  end

  initial begin
    // reset state
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_level", level, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single push, 1-cycle latency
    alu_ready = 1'b1;
    set_cmd({ADD, 4'd3, 4'd5}, 1'b0);
    cyc();
    cmd_valid = 1'b0;
    chk("t1_valid", alu_valid, 1);
    chk("t1_a", alu_a, 3);
    chk("t1_b", alu_b, 5);
    chk("t1_op", alu_op, ADD);
    cyc();
    chk("t1_valid_fall", alu_valid, 0);

    // fill to full with alu_ready low, sixth push stalls, then drain
    alu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cmd(vec[i], 1'b0);
      cyc();
    end
    set_cmd({OR, 4'hF, 4'hF}, 1'b0);
    chk("t2_cmd_ready", cmd_ready, 0);
    chk("t2_level", level, 4);
    chk("t2_valid", alu_valid, 1);
    cyc();
    chk("t2_level_stall", level, 4);
    cmd_valid = 1'b0;
    alu_ready = 1'b1;
    pops0 = pops;
    repeat (5) cyc();
    chk("t2_drain_pops", pops - pops0, 5);
    chk("t2_drain_valid", alu_valid, 0);
    chk("t2_drain_level", level, 0);

    // full with a same-cycle pop: push refused, room appears next cycle
    alu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cmd(vec[4 - i], 1'b0);
      cyc();
    end
    set_cmd({SLT, 4'h2, 4'h9}, 1'b0);
    alu_ready = 1'b1;
    chk("t3_ready_full", cmd_ready, 0);
    cyc();
    cmd_valid = 1'b0;
    alu_ready = 1'b0;
    chk("t3_level", level, 3);
    chk("t3_ready_next", cmd_ready, 1);
    alu_ready = 1'b1;
    repeat (5) cyc();
    chk("t3_drain_valid", alu_valid, 0);

    // forwarding of the in-flight result
    set_cmd({ADD, 4'd2, 4'd3}, 1'b0);
    cyc();
    fwd_a = 4'd5;
    set_cmd({SUB, 4'd9, 4'd1}, 1'b1);
    cyc();
    cmd_valid = 1'b0;
    cmd_fwd = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
    chk("t4_fwd_a", alu_a, 5);
`else
    chk("t4_fwd_a", alu_a, 9);
`endif
    repeat (2) cyc();

    // flush with three queued entries and a concurrent push
    alu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(vec[i], 1'b0);
      cyc();
    end
    chk("t5_level_pre", level, 3);
    set_cmd({EQU, 4'hB, 4'hB}, 1'b0);
    flush = 1'b1;
    chk("t5_ready_flush", cmd_ready, 1);
    cyc();
    flush = 1'b0;
    cmd_valid = 1'b0;
    chk("t5_level", level, 0);
    chk("t5_valid", alu_valid, 0);
    alu_ready = 1'b1;
    repeat (3) cyc();
    chk("t5_no_dropped", alu_valid, 0);

    // asynchronous reset mid-stream, then fresh traffic
    alu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(vec[i], 1'b0);
      cyc();
    end
    cmd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", alu_valid, 0);
    chk("t6_level", level, 0);
    chk("t6_ready", cmd_ready, 1);
    chk("t6_alu_a", alu_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    alu_ready = 1'b1;
    set_cmd(vec[3], 1'b0); cyc();
    set_cmd(vec[4], 1'b0); cyc();
    set_cmd(vec[0], 1'b0); cyc();
    cmd_valid = 1'b0;
    repeat (4) cyc();
    chk("t6_post_valid", alu_valid, 0);
    chk("sb_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
